// File: rtl/jk_pkg.sv
// Shared mode encodings and Gray-code helpers for the JK multimode counter.
// The helpers work on 32-bit vectors, and the w argument gives the active width.
package jk_pkg;

  localparam logic [1:0] MODE_JK   = 2'd0;
  localparam logic [1:0] MODE_BIN  = 2'd1;
  localparam logic [1:0] MODE_GRAY = 2'd2;
  localparam logic [1:0] MODE_JOHN = 2'd3;

  function automatic logic [31:0] width_mask(input int unsigned w);
    logic [32:0] m;
    m = (33'd1 << w) - 33'd1;
    return m[31:0];
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned w);
    return (b ^ (b >> 1)) & width_mask(w);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
    logic [32:0] b;
    b = '0;
    for (int i = 31; i >= 0; i--) begin
      b[i] = (i < int'(w)) ? (g[i] ^ b[i+1]) : 1'b0;
    end
    return b[31:0];
  endfunction

endpackage

// File: rtl/jk_multimode_counter_cell.sv
// One JK storage bit: 00 hold, 01 clear, 10 set, 11 toggle; async active-low reset to 0.
module jk_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  // NOTE: non-blocking assignment keeps every cell sampling pre-edge state, so the bank updates together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_multimode_counter.sv
// WIDTH-bit bank of JK cells. The mode logic only produces the per-bit J/K drive, and
// the cells do the state update. Modes: raw JK register, modulo-MOD binary, Gray, Johnson.
module jk_multimode_counter
  import jk_pkg::*;
#(
  parameter int              WIDTH = 4,
  parameter longint unsigned MOD   = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MOD_M1     = WIDTH'(MOD - 64'd1);
  localparam logic [WIDTH-1:0] ALL_ONES   = '1;
  localparam logic [WIDTH-1:0] JOHN_UP_TC = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] JOHN_DN_TC = WIDTH'(1);

  logic [WIDTH-1:0] j_int, k_int;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] q_bin;
  logic [WIDTH-1:0] n_bin;
  logic             q_out_of_range;
  logic             wrap_d, wrap_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .j    (j_int[i]),
      .k    (k_int[i]),
      .q    (q[i])
    );
  end

  assign q_bin          = WIDTH'(gray2bin(32'(q), WIDTH));
  assign q_out_of_range = 64'(q) >= MOD;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    j_int  = '0;
    k_int  = '0;
    n      = q;
    n_bin  = q_bin;
    wrap_d = 1'b0;
    if (load) begin
      j_int = load_val;
      k_int = ~load_val;
    end else if (en) begin
      case (mode)
        MODE_BIN: begin
          if (up_dn) begin
            if (q == MOD_M1 || q_out_of_range) begin
              n      = '0;
              wrap_d = 1'b1;
            end else begin
              n = q + WIDTH'(1);
            end
          end else if (q == '0) begin
            n      = MOD_M1;
            wrap_d = 1'b1;
          end else begin
            n = q - WIDTH'(1);
          end
        end
        MODE_GRAY: begin
          n_bin  = up_dn ? q_bin + WIDTH'(1) : q_bin - WIDTH'(1);
          n      = WIDTH'(bin2gray(32'(n_bin), WIDTH));
          wrap_d = up_dn ? (q_bin == ALL_ONES) : (q_bin == '0);
        end
        MODE_JOHN: begin
          n      = up_dn ? {q[WIDTH-2:0], ~q[WIDTH-1]} : {~q[0], q[WIDTH-1:1]};
          wrap_d = (n == '0);
        end
        default: ;
      endcase
      // Counting modes toggle exactly the bits that differ from the target.
      if (mode == MODE_JK) begin
        j_int = j;
        k_int = k;
      end else begin
        j_int = q ^ n;
        k_int = q ^ n;
      end
    end
  end

  always_comb begin
    tc = 1'b0;
    case (mode)
      MODE_BIN:  tc = up_dn ? (q == MOD_M1)     : (q == '0);
      MODE_GRAY: tc = up_dn ? (q_bin == ALL_ONES) : (q_bin == '0);
      MODE_JOHN: tc = up_dn ? (q == JOHN_UP_TC) : (q == JOHN_DN_TC);
      default:   tc = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_multimode_counter.sv
// Directed bench: a MOD=16 and a MOD=10 instance share stimulus, and each scenario task
// checks against hand-computed values.
module tb_jk_multimode_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val, j, k;
  logic [3:0] q16, q10;
  logic       tc16, tc10, wrap16, wrap10;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_multimode_counter #(.WIDTH(4), .MOD(16)) u16 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .up_dn(up_dn), .load(load),
    .load_val(load_val), .j(j), .k(k), .q(q16), .tc(tc16), .wrap(wrap16)
  );

  jk_multimode_counter #(.WIDTH(4), .MOD(10)) u10 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .up_dn(up_dn), .load(load),
    .load_val(load_val), .j(j), .k(k), .q(q10), .tc(tc10), .wrap(wrap10)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load     = 1'b1;
    load_val = v;
    step();
    load     = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (q16 !== 4'd0)   begin errors++; $display("FAIL reset_q got %h want 0", q16); end
    checks++; if (wrap16 !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap16); end
    step();
    checks++; if (q16 !== 4'd0)   begin errors++; $display("FAIL reset_held_q got %h want 0", q16); end
    checks++; if (tc16 !== 1'b0)  begin errors++; $display("FAIL reset_tc got %b want 0", tc16); end
  endtask

  task automatic test_bin16_wrap();
    logic [3:0] eq;
    rst_n = 1'b1; en = 1'b1; mode = 2'd1; up_dn = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      eq = 4'(i % 16);
      checks++; if (q16 !== eq) begin errors++; $display("FAIL bin16_q step %0d got %h want %h", i, q16, eq); end
      checks++; if (tc16 !== (eq == 4'd15)) begin errors++; $display("FAIL bin16_tc step %0d got %b want %b", i, tc16, eq == 4'd15); end
      checks++; if (wrap16 !== (i == 16)) begin errors++; $display("FAIL bin16_wrap step %0d got %b want %b", i, wrap16, i == 16); end
    end
  endtask

  task automatic test_bin10_mod();
    logic [3:0] lv [4]   = '{4'd9, 4'd0, 4'd12, 4'd12};
    logic       dir [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] eq [4]   = '{4'd0, 4'd9, 4'd0, 4'd11};
    logic       ew [4]   = '{1'b1, 1'b1, 1'b1, 1'b0};
    en = 1'b1; mode = 2'd1;
    for (int i = 0; i < 4; i++) begin
      up_dn = dir[i];
      do_load(lv[i]);
      checks++; if (q10 !== lv[i]) begin errors++; $display("FAIL bin10_load %0d got %h want %h", i, q10, lv[i]); end
      step();
      checks++; if (q10 !== eq[i]) begin errors++; $display("FAIL bin10_q %0d got %h want %h", i, q10, eq[i]); end
      checks++; if (wrap10 !== ew[i]) begin errors++; $display("FAIL bin10_wrap %0d got %b want %b", i, wrap10, ew[i]); end
    end
    up_dn = 1'b1;
    do_load(4'd9);
    checks++; if (tc10 !== 1'b1) begin errors++; $display("FAIL bin10_tc got %b want 1", tc10); end
  endtask

  task automatic test_jk_register();
    en = 1'b1; mode = 2'd0; j = 4'b1100; k = 4'b1010;
    do_load(4'b0101);
    step();
    checks++; if (q16 !== 4'b1101) begin errors++; $display("FAIL jk_apply got %b want 1101", q16); end
    checks++; if (tc16 !== 1'b0)   begin errors++; $display("FAIL jk_tc got %b want 0", tc16); end
    do_load(4'b0101);
    en = 1'b0;
    step();
    checks++; if (q16 !== 4'b0101) begin errors++; $display("FAIL jk_hold got %b want 0101", q16); end
    j = '0; k = '0;
  endtask

  task automatic test_gray();
    logic [3:0] seq [4] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
    en = 1'b1; mode = 2'd2; up_dn = 1'b1;
    do_load(4'b0000);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (q16 !== seq[i]) begin errors++; $display("FAIL gray_up %0d got %b want %b", i, q16, seq[i]); end
    end
    do_load(4'b1000);
    checks++; if (tc16 !== 1'b1) begin errors++; $display("FAIL gray_tc got %b want 1", tc16); end
    step();
    checks++; if (q16 !== 4'b0000) begin errors++; $display("FAIL gray_wrap_q got %b want 0000", q16); end
    checks++; if (wrap16 !== 1'b1) begin errors++; $display("FAIL gray_wrap got %b want 1", wrap16); end
    up_dn = 1'b0;
    step();
    checks++; if (q16 !== 4'b1000) begin errors++; $display("FAIL gray_down got %b want 1000", q16); end
    checks++; if (wrap16 !== 1'b1) begin errors++; $display("FAIL gray_down_wrap got %b want 1", wrap16); end
  endtask

  task automatic test_johnson();
    logic [3:0] seq [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    en = 1'b1; mode = 2'd3; up_dn = 1'b1;
    do_load(4'b0000);
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (q16 !== seq[i]) begin errors++; $display("FAIL john_q %0d got %b want %b", i, q16, seq[i]); end
      checks++; if (wrap16 !== (i == 7)) begin errors++; $display("FAIL john_wrap %0d got %b want %b", i, wrap16, i == 7); end
      if (i == 6) begin
        checks++; if (tc16 !== 1'b1) begin errors++; $display("FAIL john_tc got %b want 1", tc16); end
      end
    end
    up_dn = 1'b0;
    step();
    checks++; if (q16 !== 4'b1000) begin errors++; $display("FAIL john_down got %b want 1000", q16); end
    en = 1'b0;
    do_load(4'hA);
    checks++; if (q16 !== 4'hA) begin errors++; $display("FAIL load_no_en got %h want a", q16); end
  endtask

  task automatic test_async_reset();
    en = 1'b1; mode = 2'd1; up_dn = 1'b1;
    do_load(4'd6);
    step();
    checks++; if (q16 !== 4'd7) begin errors++; $display("FAIL pre_reset got %h want 7", q16); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (q16 !== 4'd0) begin errors++; $display("FAIL async_q got %h want 0", q16); end
    checks++; if (wrap16 !== 1'b0) begin errors++; $display("FAIL async_wrap got %b want 0", wrap16); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (q16 !== 4'd0) begin errors++; $display("FAIL reset_hold %0d got %h want 0", i, q16); end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step();
      checks++; if (q16 !== 4'(i)) begin errors++; $display("FAIL resume %0d got %h want %h", i, q16, 4'(i)); end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'd1; up_dn = 1'b1; load = 1'b0;
    load_val = '0; j = '0; k = '0;
    test_reset();
    test_bin16_wrap();
    test_bin10_mod();
    test_jk_register();
    test_gray();
    test_johnson();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
